// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_pkg
//  Purpose  : Shared types and constants for the frame-level sequence
//             detector (controller state encoding, default parameter values,
//             "no position" marker).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

    // Controller state encoding; width is explicit so it never grows silently.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEF_FRAME_W = 16;
    localparam int DEF_PAT_W   = 4;
    localparam int DEF_CNT_W   = 5;

    // All-ones marker meaning "no match recorded"; sliced to POS_W by users.
    localparam logic [31:0] POS_NONE = 32'hFFFF_FFFF;

endpackage : seq_detect_pkg
`default_nettype wire

// File: rtl/seq_detect_core.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_core
//  Purpose  : Bit-serial Moore pattern detector. Keeps a PAT_W-bit history,
//             a saturating valid-bit count and a registered hit flag.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             clear           - restart detection (history/valid/hit to 0)
//             bit_valid       - bit_in is consumed this cycle
//             bit_in          - serial data bit
//             pattern         - target sequence, MSB is the earliest bit
//             overlap         - 1: keep history on match, 0: require PAT_W
//                               fresh bits after a match
//             match           - a match completes on this cycle's bit
//             hit             - registered Moore match output
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detect_core #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match,
    output logic             hit
);

    localparam int VW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] w_hist_shift;
    logic [VW-1:0]    vcnt_q, vcnt_d;
    logic [VW-1:0]    w_vcnt_inc;
    logic             hit_q, hit_d;

    // A one-bit history is just the incoming bit.
    generate
        if (PAT_W == 1) begin : g_hist_one
            assign w_hist_shift = bit_in;
        end else begin : g_hist_wide
            assign w_hist_shift = {hist_q[PAT_W-2:0], bit_in};
        end
    endgenerate

    always_comb begin
        w_vcnt_inc = (vcnt_q == VW'(PAT_W)) ? vcnt_q : vcnt_q + VW'(1);
        // Compare against the history as it will be after this bit, so the
        // registered hit appears in the cycle following the completing bit.
        match  = !clear && bit_valid && (w_hist_shift == pattern) &&
                 (w_vcnt_inc == VW'(PAT_W));
        hist_d = hist_q;
        vcnt_d = vcnt_q;
        hit_d  = match;
        if (clear) begin
            hist_d = '0;
            vcnt_d = '0;
        end else if (bit_valid) begin
            hist_d = w_hist_shift;
            vcnt_d = (match && !overlap) ? '0 : w_vcnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            vcnt_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            vcnt_q <= vcnt_d;
            hit_q  <= hit_d;
        end
    end

    assign hit = hit_q;

endmodule : seq_detect_core
`default_nettype wire

// File: rtl/seq_detect_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_frame_ctrl
//  Purpose  : Frame controller for a programmable-pattern Moore sequence
//             detector. Latches a frame, serialises it MSB-first into
//             seq_detect_core, counts matches and pulses done at frame end.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             start           - run request, sampled only in IDLE
//             frame_data      - frame to scan, bit FRAME_W-1 sent first
//             pattern         - target sequence, bit PAT_W-1 earliest
//             overlap         - 1 overlapping / 0 non-overlapping detection
//             busy            - high while bits are shifted
//             hit             - registered Moore match output
//             done            - one-cycle end-of-frame pulse
//             match_count     - saturating match count of last/current frame
//             first_pos       - index of first match (SEQ_FIRST_POS_EN only)
//  Option   : define SEQ_FIRST_POS_EN to add the first_pos port/register.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detect_frame_ctrl
    import seq_detect_pkg::*;
#(
    parameter  int FRAME_W = DEF_FRAME_W,
    parameter  int PAT_W   = DEF_PAT_W,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int POS_W   = $clog2(FRAME_W) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame_data,
    input  logic [PAT_W-1:0]   pattern,
    input  logic               overlap,
    output logic               busy,
    output logic               hit,
    output logic               done,
    output logic [CNT_W-1:0]   match_count
`ifdef SEQ_FIRST_POS_EN
    ,
    output logic [POS_W-1:0]   first_pos
`endif
);

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic               overlap_q, overlap_d;
    logic [POS_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SEQ_FIRST_POS_EN
    logic [POS_W-1:0]   first_pos_q, first_pos_d;
`endif

    logic w_clear;
    logic w_bit_valid;
    logic w_match;

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        pattern_d   = pattern_q;
        overlap_d   = overlap_q;
        idx_d       = idx_q;
        count_d     = count_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        w_clear     = 1'b0;
        w_bit_valid = 1'b0;
`ifdef SEQ_FIRST_POS_EN
        first_pos_d = first_pos_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    frame_d     = frame_data;
                    pattern_d   = pattern;
                    overlap_d   = overlap;
                    idx_d       = '0;
                    count_d     = '0;
                    w_clear     = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_SHIFT;
`ifdef SEQ_FIRST_POS_EN
                    first_pos_d = POS_NONE[POS_W-1:0];
`endif
                end
            end
            ST_SHIFT: begin
                // The latched frame is shifted left so its MSB is always the
                // next bit to send; idx_q tracks which bit that is.
                w_bit_valid = 1'b1;
                frame_d     = frame_q << 1;
                idx_d       = idx_q + POS_W'(1);
                if (idx_q == POS_W'(FRAME_W - 1)) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Count/position update on the same edge that raises hit.
        if (w_match) begin
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
`ifdef SEQ_FIRST_POS_EN
            if (first_pos_q == POS_NONE[POS_W-1:0]) begin
                first_pos_d = idx_q;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            pattern_q   <= '0;
            overlap_q   <= 1'b0;
            idx_q       <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_FIRST_POS_EN
            first_pos_q <= POS_NONE[POS_W-1:0];
`endif
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            pattern_q   <= pattern_d;
            overlap_q   <= overlap_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SEQ_FIRST_POS_EN
            first_pos_q <= first_pos_d;
`endif
        end
    end

    seq_detect_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .bit_valid (w_bit_valid),
        .bit_in    (frame_q[FRAME_W-1]),
        .pattern   (pattern_q),
        .overlap   (overlap_q),
        .match     (w_match),
        .hit       (hit)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign match_count = count_q;
`ifdef SEQ_FIRST_POS_EN
    assign first_pos   = first_pos_q;
`endif

endmodule : seq_detect_frame_ctrl
`default_nettype wire

// File: tb/tb_seq_detect_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detect_frame_ctrl
//  Purpose  : Self-checking bench for seq_detect_frame_ctrl. Two instances
//             share stimulus: CNT_W=5 (full check) and CNT_W=3 (saturation).
//             Expected behaviour comes from a window-scan reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_frame_ctrl;

    localparam int FW = 16;
    localparam int PW = 4;
    localparam int PSW = $clog2(FW) + 1;
    localparam logic [PSW-1:0] NONE = '1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [FW-1:0] frame_data;
    logic [PW-1:0] pattern;
    logic          overlap;
    logic          busy, hit, done;
    logic [4:0]    match_count;
    logic          busy3, hit3, done3;
    logic [2:0]    match_count3;
`ifdef SEQ_FIRST_POS_EN
    logic [PSW-1:0] first_pos, first_pos3;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_prev_cnt  = 0;
    int exp_prev_cnt3 = 0;

    always #5 clk = ~clk;

    seq_detect_frame_ctrl #(.FRAME_W(FW), .PAT_W(PW), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .frame_data(frame_data),
        .pattern(pattern), .overlap(overlap), .busy(busy), .hit(hit),
        .done(done), .match_count(match_count)
`ifdef SEQ_FIRST_POS_EN
        , .first_pos(first_pos)
`endif
    );

    seq_detect_frame_ctrl #(.FRAME_W(FW), .PAT_W(PW), .CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .frame_data(frame_data),
        .pattern(pattern), .overlap(overlap), .busy(busy3), .hit(hit3),
        .done(done3), .match_count(match_count3)
`ifdef SEQ_FIRST_POS_EN
        , .first_pos(first_pos3)
`endif
    );

    // Bit i of the result is set when the bit at frame index i completes a
    // match. In non-overlapping mode a new match needs PW bits after the last.
    function automatic logic [FW-1:0] model_hits(input logic [FW-1:0] f,
                                                  input logic [PW-1:0] p,
                                                  input logic ov);
        logic [FW-1:0] m;
        logic [FW-1:0] sh;
        int last;
        m = '0;
        last = -1;
        for (int i = 0; i < FW; i++) begin
            sh = f >> (FW - 1 - i);
            if ((i - last) >= PW && sh[PW-1:0] == p) begin
                m[i] = 1'b1;
                if (!ov) last = i;
            end
        end
        return m;
    endfunction

    // Called at a negedge just before an IDLE cycle; ends at the DONE negedge.
    task automatic run_frame(input logic [FW-1:0] f, input logic [PW-1:0] p,
                             input logic ov, input bit hold);
        logic [FW-1:0] m;
        int ecnt, efirst;
        logic ehit;
        m = model_hits(f, p, ov);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 ||
            match_count !== 5'(exp_prev_cnt) || match_count3 !== 3'(exp_prev_cnt3)) begin
            n_err++;
            $display("FAIL idle_hold: busy=%b done=%b hit=%b cnt=%0d cnt3=%0d expected 0 0 0 %0d %0d",
                     busy, done, hit, match_count, match_count3, exp_prev_cnt, exp_prev_cnt3);
        end
        frame_data = f; pattern = p; overlap = ov; start = 1'b1;
        for (int c = 1; c <= FW + 1; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            frame_data = FW'($urandom);
            pattern    = PW'($urandom);
            overlap    = 1'($urandom);
            ehit   = (c >= 2) ? m[c-2] : 1'b0;
            ecnt   = 0;
            efirst = int'(NONE);
            for (int k = 0; k <= c - 2; k++) begin
                if (m[k]) begin
                    ecnt++;
                    if (efirst == int'(NONE)) efirst = k;
                end
            end
            n_vec++;
            if (busy !== (c <= FW)) begin
                n_err++; $display("FAIL busy c=%0d: got %b expected %b", c, busy, (c <= FW));
            end
            n_vec++;
            if (done !== (c == FW + 1)) begin
                n_err++; $display("FAIL done c=%0d: got %b expected %b", c, done, (c == FW + 1));
            end
            n_vec++;
            if (hit !== ehit) begin
                n_err++; $display("FAIL hit c=%0d f=%h p=%h ov=%b: got %b expected %b", c, f, p, ov, hit, ehit);
            end
            n_vec++;
            if (match_count !== 5'((ecnt > 31) ? 31 : ecnt)) begin
                n_err++; $display("FAIL count c=%0d: got %0d expected %0d", c, match_count, (ecnt > 31) ? 31 : ecnt);
            end
            n_vec++;
            if (match_count3 !== 3'((ecnt > 7) ? 7 : ecnt)) begin
                n_err++; $display("FAIL count_sat c=%0d: got %0d expected %0d", c, match_count3, (ecnt > 7) ? 7 : ecnt);
            end
`ifdef SEQ_FIRST_POS_EN
            n_vec++;
            if (first_pos !== PSW'(efirst)) begin
                n_err++; $display("FAIL first_pos c=%0d: got %0d expected %0d", c, first_pos, efirst);
            end
`endif
            exp_prev_cnt  = (ecnt > 31) ? 31 : ecnt;
            exp_prev_cnt3 = (ecnt > 7) ? 7 : ecnt;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; frame_data = '0; pattern = '0; overlap = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || hit !== 1'b0 || done !== 1'b0 || match_count !== 5'd0 || match_count3 !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b hit=%b done=%b cnt=%0d cnt3=%0d expected all 0",
                     busy, hit, done, match_count, match_count3);
        end
`ifdef SEQ_FIRST_POS_EN
        n_vec++;
        if (first_pos !== NONE) begin
            n_err++; $display("FAIL reset_first_pos: got %0d expected %0d", first_pos, NONE);
        end
`endif
        reset = 1'b0;
        exp_prev_cnt = 0; exp_prev_cnt3 = 0;
    endtask

    task automatic test_directed();
        run_frame(16'b1101_1010_1101_0110, 4'b1101, 1'b1, 1'b0);
        n_vec++;
        if (match_count !== 5'd3) begin
            n_err++; $display("FAIL s1_count: got %0d expected 3", match_count);
        end
`ifdef SEQ_FIRST_POS_EN
        n_vec++;
        if (first_pos !== 5'd3) begin
            n_err++; $display("FAIL s1_first_pos: got %0d expected 3", first_pos);
        end
`endif
        run_frame(16'b1101_1010_1101_0110, 4'b1101, 1'b0, 1'b0);
        n_vec++;
        if (match_count !== 5'd2) begin
            n_err++; $display("FAIL s2_count: got %0d expected 2", match_count);
        end
        run_frame(16'hFFFF, 4'b1111, 1'b1, 1'b0);
        n_vec++;
        if (match_count !== 5'd13 || match_count3 !== 3'd7) begin
            n_err++; $display("FAIL s3_ov_count: got %0d/%0d expected 13/7", match_count, match_count3);
        end
        run_frame(16'hFFFF, 4'b1111, 1'b0, 1'b0);
        n_vec++;
        if (match_count !== 5'd4) begin
            n_err++; $display("FAIL s3_nov_count: got %0d expected 4", match_count);
        end
        run_frame(16'h0000, 4'b1101, 1'b1, 1'b0);
        n_vec++;
        if (match_count !== 5'd0) begin
            n_err++; $display("FAIL s4_zero_count: got %0d expected 0", match_count);
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        frame_data = 16'b1101_1010_1101_0110; pattern = 4'b1101; overlap = 1'b1; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = (c == 3);
            n_vec++;
            if (busy !== 1'b1 || match_count !== 5'((c == 5) ? 1 : 0)) begin
                n_err++; $display("FAIL abort_run c=%0d: busy=%b cnt=%0d expected 1 %0d",
                                  c, busy, match_count, (c == 5) ? 1 : 0);
            end
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || hit !== 1'b0 || done !== 1'b0 || match_count !== 5'd0) begin
            n_err++; $display("FAIL abort_reset: busy=%b hit=%b done=%b cnt=%0d expected 0 0 0 0",
                              busy, hit, done, match_count);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL abort_quiet c=%0d: done=%b busy=%b expected 0 0", c, done, busy);
            end
        end
        exp_prev_cnt = 0; exp_prev_cnt3 = 0;
        run_frame(16'b1101_1010_1101_0110, 4'b1101, 1'b1, 1'b0);
        n_vec++;
        if (match_count !== 5'd3) begin
            n_err++; $display("FAIL abort_rerun_count: got %0d expected 3", match_count);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(16'hFFFF, 4'b1111, 1'b1, 1'b1);
        for (int n = 0; n < 4; n++) begin
            run_frame(FW'($urandom), PW'($urandom), 1'($urandom), 1'b1);
        end
        start = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            run_frame(FW'($urandom), PW'($urandom_range(0, 3) == 0 ? 4'b1010 : $urandom),
                      1'($urandom), 1'($urandom));
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
        test_random();
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || match_count !== 5'(exp_prev_cnt)) begin
            n_err++; $display("FAIL final_idle: busy=%b done=%b cnt=%0d expected 0 0 %0d",
                              busy, done, match_count, exp_prev_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seq_detect_frame_ctrl
`default_nettype wire
